// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, FSM states and sizing helper for the bitmap text printer
package display_pkg;

    localparam int SIDE_WIDTH = 8;
    localparam int SQUARES    = 64;

    localparam logic [7:0] DOT     = 8'h2E;
    localparam logic [7:0] CROSS   = 8'h58;
    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] NEWLINE = 8'h0A;
    localparam logic [7:0] DIGIT0  = 8'h30;
    localparam logic [7:0] HEXA    = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LABEL,
        ST_SQUARE,
        ST_SEP,
        ST_GAP,
        ST_EOL,
        ST_TRAIL,
        ST_DONE
    } state_e;

    // Each channel contributes 16 square/space bytes plus a gap, the gap of channel 0 is the newline.
    function automatic int bytes_per_print(input int channels, input int labels);
        return SIDE_WIDTH * (channels * 17 - 1 + 1 + 2 * labels) + 1;
    endfunction

endpackage

// File: rtl/display_square_char.sv
// rtl/display_square_char.sv - maps one square value to its ASCII glyph
module display_square_char
    import display_pkg::*;
#(
    parameter int PIECE_WIDTH = 1
) (
    input  logic [PIECE_WIDTH-1:0] value_i,
    output logic [7:0]             char_o
);

    logic [3:0] nib;

    assign nib = 4'(value_i);

    always_comb begin
        char_o = DOT;
        if (value_i != '0) begin
            if (PIECE_WIDTH == 1) begin
                char_o = CROSS;
            end else if (nib < 4'd10) begin
                char_o = DIGIT0 + {4'd0, nib};
            end else begin
                char_o = HEXA + {4'd0, nib} - 8'd10;
            end
        end
    end

endmodule

// File: rtl/display_bitmap_stream.sv
// rtl/display_bitmap_stream.sv - captures side-by-side 8x8 bitmaps and streams them as ASCII text
module display_bitmap_stream
    import display_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int PIECE_WIDTH = 1,
    parameter int LABELS      = 0,
    parameter int FLIP        = 0,
    parameter int SIM_PRINT   = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [CHANNELS*SQUARES*PIECE_WIDTH-1:0] bitmap,
    input  logic                                    bitmap_valid,
    output logic                                    bitmap_ready,
    output logic [7:0]                              char_out,
    output logic                                    char_valid,
    input  logic                                    char_ready,
    output logic                                    busy,
    output logic                                    display_done
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW = CHANNELS * SQUARES * PIECE_WIDTH;
    localparam int IW = CW + 6;

    state_e          state_q, state_d;
    logic            lbl_q, lbl_d;
    logic [2:0]      row_q, row_d;
    logic [2:0]      col_q, col_d;
    logic [CW-1:0]   chan_q, chan_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [7:0]      char_q, char_d;
    logic            valid_q, valid_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            fire;
    logic [2:0]      rank_d, file_d;
    logic [IW-1:0]   sq_idx;
    logic [PIECE_WIDTH-1:0] sq_val;
    logic [7:0]      sq_char;

    assign fire = valid_q && char_ready;

    // row/col count printed order; the viewpoint decides which rank/file they address.
    always_comb begin
        state_d = state_q;
        lbl_d   = lbl_q;
        row_d   = row_q;
        col_d   = col_q;
        chan_d  = chan_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (bitmap_valid) begin
                    buf_d   = bitmap;
                    row_d   = 3'd0;
                    col_d   = 3'd0;
                    chan_d  = '0;
                    lbl_d   = 1'b0;
                    state_d = (LABELS != 0) ? ST_LABEL : ST_SQUARE;
                end
            end
            ST_LABEL: begin
                if (fire) begin
                    if (!lbl_q) begin
                        lbl_d = 1'b1;
                    end else begin
                        lbl_d   = 1'b0;
                        state_d = ST_SQUARE;
                    end
                end
            end
            ST_SQUARE: begin
                if (fire) begin
                    state_d = ST_SEP;
                end
            end
            ST_SEP: begin
                if (fire) begin
                    if (col_q == 3'd7) begin
                        col_d = 3'd0;
                        if (int'(chan_q) < CHANNELS - 1) begin
                            chan_d  = chan_q + CW'(1);
                            state_d = ST_GAP;
                        end else begin
                            chan_d  = '0;
                            state_d = ST_EOL;
                        end
                    end else begin
                        col_d   = col_q + 3'd1;
                        state_d = ST_SQUARE;
                    end
                end
            end
            ST_GAP: begin
                if (fire) begin
                    state_d = ST_SQUARE;
                end
            end
            ST_EOL: begin
                if (fire) begin
                    if (row_q != 3'd7) begin
                        row_d   = row_q + 3'd1;
                        state_d = (LABELS != 0) ? ST_LABEL : ST_SQUARE;
                    end else begin
                        row_d   = 3'd0;
                        state_d = ST_TRAIL;
                    end
                end
            end
            ST_TRAIL: begin
                if (fire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rank_d = (FLIP != 0) ? row_d : (3'd7 - row_d);
    assign file_d = (FLIP != 0) ? (3'd7 - col_d) : col_d;
    assign sq_idx = {chan_d, rank_d, file_d};
    assign sq_val = buf_d[int'(sq_idx) * PIECE_WIDTH +: PIECE_WIDTH];

    display_square_char #(
        .PIECE_WIDTH(PIECE_WIDTH)
    ) u_square_char (
        .value_i(sq_val),
        .char_o (sq_char)
    );

    // The byte for the next state is prepared alongside it so char_out is a plain register.
    always_comb begin
        char_d = 8'h00;
        case (state_d)
            ST_LABEL:         char_d = lbl_d ? SPACE : (DIGIT0 + 8'd1 + {5'd0, rank_d});
            ST_SQUARE:        char_d = sq_char;
            ST_SEP, ST_GAP:   char_d = SPACE;
            ST_EOL, ST_TRAIL: char_d = NEWLINE;
            default:          char_d = 8'h00;
        endcase
    end

    assign valid_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    assign ready_d = (state_d == ST_IDLE);
    assign busy_d  = (state_d != ST_IDLE);
    assign done_d  = (state_d == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lbl_q   <= 1'b0;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            chan_q  <= '0;
            buf_q   <= '0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lbl_q   <= lbl_d;
            row_q   <= row_d;
            col_q   <= col_d;
            chan_q  <= chan_d;
            buf_q   <= buf_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bitmap_ready = ready_q;
    assign char_out     = char_q;
    assign char_valid   = valid_q;
    assign busy         = busy_q;
    assign display_done = done_q;

`ifndef SYNTHESIS
    if (SIM_PRINT != 0) begin : g_sim_print
        always @(posedge clk) begin
            if (!reset && valid_q && char_ready) begin
                $write("%c", char_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_display_bitmap_stream.sv
// tb/tb_display_bitmap_stream.sv - scoreboard bench over three printer configurations
module tb_display_bitmap_stream;
    import display_pkg::*;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    string first_frame [3];
    bit    fin [3];

    function automatic string vis(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++)
            r = (s[i] == 8'h0A) ? {r, "|"} : $sformatf("%s%c", r, s[i]);
        return r;
    endfunction

    task automatic chk(input int inst, input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL inst=%0d %s actual=%0h required=%0h", inst, name, act, req);
        end
    endtask

    task automatic chk_str(input int inst, input string name, input string act, input string req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL inst=%0d %s actual=\"%s\" required=\"%s\"", inst, name, vis(act), vis(req));
        end
    endtask

    function automatic string get_line(input string s, input int n);
        string r;
        int    ln;
        r  = "";
        ln = 1;
        for (int i = 0; i < s.len(); i++) begin
            if (ln == n) r = $sformatf("%s%c", r, s[i]);
            if (s[i] == 8'h0A) ln++;
        end
        return r;
    endfunction

    // Text of one print, straight from the row/line layout rules.
    function automatic string model_frame(input int ch, input int pw, input int lab, input int flp,
                                          input logic [1023:0] bm);
        string s;
        int    rank, file, v;
        byte   c;
        s = "";
        for (int r = 0; r < 8; r++) begin
            rank = (flp != 0) ? r : 7 - r;
            if (lab != 0) s = $sformatf("%s%0d ", s, rank + 1);
            for (int k = 0; k < ch; k++) begin
                if (k > 0) s = {s, " "};
                for (int f = 0; f < 8; f++) begin
                    file = (flp != 0) ? 7 - f : f;
                    v = int'(bm >> ((k * 64 + rank * 8 + file) * pw)) & ((1 << pw) - 1);
                    if (v == 0)       c = ".";
                    else if (pw == 1) c = "X";
                    else if (v < 10)  c = byte'(48 + v);
                    else              c = byte'(55 + v);
                    s = $sformatf("%s%c ", s, c);
                end
            end
            s = {s, "\n"};
        end
        return {s, "\n"};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH  = (g == 0) ? 1 : (g == 1) ? 2 : 3;
        localparam int PW  = (g == 2) ? 4 : 1;
        localparam int LAB = (g == 1) ? 1 : 0;
        localparam int FLP = (g == 2) ? 1 : 0;
        localparam int BW  = CH * 64 * PW;
        localparam int NB  = bytes_per_print(CH, LAB);
        localparam logic [1023:0] DIR = (g == 0) ? 1024'h1 :
                                        (g == 1) ? {960'h0, 64'hFFFF_FFFF_FFFF_FFFF} :
                                                   (1024'hB << 112);

        logic          rst, bvalid, bready, cvalid, cready, busy, done;
        logic [7:0]    cout;
        logic [BW-1:0] bm;

        logic [7:0] exp_q [$];
        logic [7:0] exp_b;
        int    cyc = 0, xfer_cnt = 0, frames_done = 0, acc_cnt = 0, done_pending = 0;
        int    acc_cyc = 0, first_cyc = 0, last_xfer = 0;
        bit    prev_stall = 0, prev_done = 0, acc_pend = 0, rnd_mode = 0;
        logic [7:0] prev_char = 8'h00;
        string cur_frame = "", last_frame = "";

        display_bitmap_stream #(
            .CHANNELS(CH), .PIECE_WIDTH(PW), .LABELS(LAB), .FLIP(FLP), .SIM_PRINT(0)
        ) dut (
            .clk(clk), .reset(rst), .bitmap(bm), .bitmap_valid(bvalid), .bitmap_ready(bready),
            .char_out(cout), .char_valid(cvalid), .char_ready(cready), .busy(busy),
            .display_done(done)
        );

        initial forever begin
            @(posedge clk);
            #1;
            cready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end

        always @(negedge clk) begin
            string s;
            cyc++;
            if (rst) begin
                prev_stall = 0;
                prev_done  = 0;
                acc_pend   = 0;
            end else begin
                chk(g, "ready_vs_busy", bready == !busy, bready, !busy);
                if (prev_stall)
                    chk(g, "stall_stable", cvalid && cout == prev_char, {cvalid, cout}, {1'b1, prev_char});
                if (prev_done)
                    chk(g, "ready_after_done", bready && !busy, bready, 1);
                if (acc_pend) begin
                    chk(g, "first_valid_latency", cvalid == 1'b1, cvalid, 1);
                    acc_pend  = 0;
                    first_cyc = cyc;
                end
                if (cvalid && cready) begin
                    chk(g, "byte_expected", exp_q.size() != 0, cout, 0);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        chk(g, "byte", cout == exp_b, cout, exp_b);
                    end
                    cur_frame = $sformatf("%s%c", cur_frame, cout);
                    xfer_cnt++;
                    last_xfer = cyc;
                end
                if (done) begin
                    chk(g, "done_expected", done_pending > 0 && exp_q.size() == 0,
                        done_pending, exp_q.size());
                    chk(g, "done_after_last", last_xfer == cyc - 1, cyc - last_xfer, 1);
                    if (!rnd_mode) chk(g, "done_cycles", cyc - first_cyc == NB, cyc - first_cyc, NB);
                    if (done_pending > 0) done_pending--;
                    last_frame = cur_frame;
                    cur_frame  = "";
                    frames_done++;
                end
                if (bvalid && bready) begin
                    s = model_frame(CH, PW, LAB, FLP, 1024'(bm));
                    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
                    done_pending++;
                    acc_cnt++;
                    acc_pend = 1;
                    acc_cyc  = cyc;
                end
                prev_stall = cvalid && !cready;
                prev_char  = cout;
                prev_done  = done;
            end
        end

        task automatic rand_bm();
            for (int s = 0; s < CH * 64; s++)
                bm[s*PW +: PW] = ($urandom_range(0, 2) == 0) ? PW'(0) : PW'($urandom);
        endtask

        task automatic send();
            bvalid = 1'b1;
            @(posedge clk);
            #1;
            bvalid = 1'b0;
        endtask

        task automatic wait_idle(input string name);
            int t;
            t = 0;
            while (t < 6000 && !(done_pending == 0 && exp_q.size() == 0 && bready)) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk(g, name, t < 6000, t, 6000);
            repeat (2) @(posedge clk);
            #1;
        endtask

        initial begin : stim
            string f2;
            int    base, acc_base, t;
            rst = 1'b1; bvalid = 1'b0; bm = '0; cready = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk(g, "rst_ready", bready == 1'b1, bready, 1);
            chk(g, "rst_valid", cvalid == 1'b0, cvalid, 0);
            chk(g, "rst_char", cout == 8'h00, cout, 0);
            chk(g, "rst_busy", busy == 1'b0, busy, 0);
            chk(g, "rst_done", done == 1'b0, done, 0);
            rst = 1'b0;
            @(posedge clk);
            #1;

            bm = DIR[BW-1:0];
            send();
            wait_idle("frame1_timeout");
            first_frame[g] = last_frame;
            chk(g, "frame1_len", last_frame.len() == NB, last_frame.len(), NB);

            rand_bm();
            rnd_mode = 1;
            send();
            wait_idle("bp_timeout");
            rnd_mode = 0;
            f2 = last_frame;
            @(posedge clk);
            #1;
            send();
            wait_idle("rerun_timeout");
            chk_str(g, "bp_vs_full", last_frame, f2);

            rand_bm();
            base = xfer_cnt;
            send();
            t = 0;
            while (xfer_cnt < base + 50 && t < 2000) begin
                @(posedge clk);
                t++;
            end
            chk(g, "abort_reach", xfer_cnt >= base + 50, xfer_cnt - base, 50);
            #3;
            rst = 1'b1;
            exp_q.delete();
            done_pending = 0;
            cur_frame    = "";
            #1;
            chk(g, "abort_valid", cvalid == 1'b0, cvalid, 0);
            chk(g, "abort_busy", busy == 1'b0, busy, 0);
            @(posedge clk);
            #3;
            rst  = 1'b0;
            base = frames_done;
            repeat (20) @(posedge clk);
            #1;
            chk(g, "abort_no_done", frames_done == base, frames_done - base, 0);
            rand_bm();
            send();
            wait_idle("post_abort_timeout");
            chk(g, "post_abort_len", last_frame.len() == NB, last_frame.len(), NB);

            rand_bm();
            base     = frames_done;
            acc_base = acc_cnt;
            rnd_mode = 1;
            bvalid   = 1'b1;
            repeat (30) @(posedge clk);
            #1;
            rand_bm();
            t = 0;
            while (frames_done < base + 2 && t < 8000) begin
                @(posedge clk);
                t++;
            end
            #1;
            bvalid = 1'b0;
            chk(g, "held_two_frames", frames_done >= base + 2, frames_done - base, 2);
            rnd_mode = 0;
            wait_idle("held_timeout");
            chk(g, "held_accepts", acc_cnt - acc_base == 2, acc_cnt - acc_base, 2);
            chk(g, "queue_empty", exp_q.size() == 0, exp_q.size(), 0);
            fin[g] = 1'b1;
        end
    end

    initial begin : summary
        int t;
        t = 0;
        while (!(fin[0] && fin[1] && fin[2]) && t < 80000) begin
            @(posedge clk);
            t++;
        end
        chk(-1, "all_finished", t < 80000, t, 80000);
        chk(-1, "len_a", first_frame[0].len() == 137, first_frame[0].len(), 137);
        chk(-1, "len_b", first_frame[1].len() == 289, first_frame[1].len(), 289);
        chk(-1, "len_c", first_frame[2].len() == 409, first_frame[2].len(), 409);
        chk_str(-1, "a_line1", get_line(first_frame[0], 1), ". . . . . . . . \n");
        chk_str(-1, "a_line8", get_line(first_frame[0], 8), "X . . . . . . . \n");
        chk_str(-1, "b_line1", get_line(first_frame[1], 1), "8 X X X X X X X X  . . . . . . . . \n");
        chk_str(-1, "c_line4", get_line(first_frame[2], 4),
                ". . . B . . . .  . . . . . . . .  . . . . . . . . \n");
        chk_str(-1, "c_line5", get_line(first_frame[2], 5),
                ". . . . . . . .  . . . . . . . .  . . . . . . . . \n");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_bitmap_stream.md
Name: display_bitmap_stream

Overview:
- Parametrised successor of the single-bitmap debug printer.
- Captures CHANNELS side-by-side 8x8 board bitmaps, each square PIECE_WIDTH bits wide, and serialises them as ASCII text on a valid/ready byte stream.
- The stream can feed a UART or the testbench. Optionally mirrors the text to the simulator console.
- Adds input buffering, backpressure, rank labels and board flip.

Parameters:
- CHANNELS, 2: number of bitmaps printed side by side (1..4).
- PIECE_WIDTH, 1: bits per square (1..4).
- LABELS, 0: 1 = prefix each row with rank digit and space.
- FLIP, 0: 1 = print from black's viewpoint.
- SIM_PRINT, 1: 1 = also $write each accepted char (non-synth only).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- bitmap  input  CHANNELS*64*PIECE_WIDTH  channel c, square s at bits [(c*64+s)*PIECE_WIDTH +: PIECE_WIDTH]; s = rank*8+file.
- bitmap_valid  input  1  request to print.
- bitmap_ready  output  1  high only in IDLE.
- char_out  output  8  ASCII byte.
- char_valid  output  1  char_out valid.
- char_ready  input  1  sink accepts byte.
- busy  output  1  high in any state other than IDLE.
- display_done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset values: bitmap_ready=1, char_valid=0, char_out=0, busy=0, display_done=0; state=IDLE. All counters zero.
- Reset is asynchronous and takes effect mid-print: stream aborts with no further bytes; no display_done.
- Accept: bitmap_valid && bitmap_ready copies bitmap into internal buffer. Caller may then change bitmap. First char_valid appears the next cycle.
- Byte handshake: a byte transfers when char_valid && char_ready. While char_valid && !char_ready, char_out holds stable and state is frozen. char_valid stays high between bytes with no bubbles (one byte per cycle max).
- Square char: value 0 -> '.'. Nonzero with PIECE_WIDTH=1 -> 'X'. Nonzero with PIECE_WIDTH>1 -> uppercase hex digit of the value ('1'..'9','A'..'F').
- Row order:
  - FLIP=0: ranks 7 down to 0, files 0..7.
  - FLIP=1: ranks 0 up to 7, files 7..0.
- Row line, in order:
  - if LABELS: rank digit '1'+rank, then ' '.
  - channel 0: 8 x (square char, ' ').
  - each channel c>0: ' ' gap, then 8 x (square char, ' ').
  - '\n'.
- After the last row, one extra '\n'; then DONE.
- Byte count per print: 8*(CHANNELS*17 - 1 + 1 + 2*LABELS) + 1.
- FSM:
  - IDLE -(accept)-> LABEL if LABELS, else SQUARE.
  - LABEL: rank digit, then space -> SQUARE.
  - SQUARE: char -> SEP.
  - SEP: ' '. After file 7 -> GAP if more channels, else EOL; otherwise -> SQUARE.
  - GAP: ' ' -> SQUARE of the next channel.
  - EOL: '\n'. If more rows -> LABEL/SQUARE; else -> TRAIL.
  - TRAIL: '\n' -> DONE.
  - DONE: display_done=1 for one cycle -> IDLE.
- bitmap_valid during busy or DONE is ignored; no queueing. bitmap_ready returns to 1 the cycle after DONE.
- Counters: rank 3b, file 3b, channel $clog2(CHANNELS) min 1b. Square index computed from these as 6b plus channel offset; no wrap outside the buffer.
- SIM_PRINT: $write("%c") on each transfer, not on assertion.

Decomposition:
- Shared package display_pkg holds:
  - ASCII constants: DOT, CROSS, SPACE, NEWLINE, DIGIT0, HEXA.
  - SIDE_WIDTH=8, SQUARES=64.
  - FSM state enum.
  - bytes_per_print(CHANNELS, LABELS) function for the bench.
- One sub-module: display_square_char, combinational. Maps a PIECE_WIDTH value to ASCII, parametrised by PIECE_WIDTH.

Test Plan:
- CHANNELS=1, PW=1, bitmap=64'h1 (a1 only), char_ready=1 -> 137 bytes. Line 8 = ". X . . . . . . . " is wrong; required line 8 = "X . . . . . . . \n". Lines 1-7 are all '.'. display_done pulses once, 137 cycles after the first char_valid.
- CHANNELS=2, LABELS=1, ch0=all ones, ch1=0 -> 289 bytes. First line = "8 X X X X X X X X  . . . . . . . . \n".
- PW=4, square e4 (s=28)=4'hB, FLIP=1 -> 'B' is on the 4th printed line at file position 4 of 8 (files listed 7..0); all else '.'.
- Random char_ready at 30% duty -> byte sequence identical to the char_ready=1 run; char_out is stable whenever valid && !ready.
- Assert reset for 1 cycle at byte 50 -> char_valid=0 and busy=0 immediately; no display_done. A new request prints a full, correct frame.
- bitmap_valid held high through a print, with bitmap changed mid-print -> output reflects the captured value. Second print starts the cycle after display_done, and only one print occurs per ready window.
